// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing helpers shared by the sync FIFO read/write control and output stage.
package fifo_pkg;
    function automatic int fwft_bd(input int rd_lat);
        return rd_lat + 2;
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/rd_lat_pipe.sv
// rd_lat_pipe: tracks granted reads through the RAM latency; emits push and in-flight count.
module rd_lat_pipe #(
    parameter int RD_LAT = 1,
    parameter int NW     = $clog2(RD_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ren,
    output logic          push,
    output logic [NW-1:0] inflight
);
    logic [RD_LAT-1:0] pipe;
    always_ff @(posedge clk) begin
        if (rst) pipe <= '0;
        else begin
            pipe[0] <= ren;
            for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end
    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LAT; k++) inflight = inflight + NW'(pipe[k]);
    end
    assign push = pipe[RD_LAT-1];
endmodule

// File: rtl/fifo_fwft_out_stage.sv
// fifo_fwft_out_stage: FWFT skid buffer behind the FIFO RAM, credit-based read requests.
module fifo_fwft_out_stage
    import fifo_pkg::*;
#(
    parameter  int DW     = 32,
    parameter  int RD_LAT = 1,
    localparam int BD     = fwft_bd(RD_LAT),
    localparam int CW     = cnt_w(BD)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_ready_m,
    input  logic          i_ren,
    input  logic [DW-1:0] i_rdata,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_count,
    output logic          o_err
);
    localparam int PW = $clog2(BD);
    localparam int NW = $clog2(RD_LAT + 1);
    logic [DW-1:0] mem [BD];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [NW-1:0] inflight;
    logic [CW:0]   used;
    logic          push, wr, pop, full, err;
    rd_lat_pipe #(.RD_LAT(RD_LAT), .NW(NW)) u_pipe (
        .clk(i_clk), .rst(i_rst), .ren(i_ren), .push(push), .inflight(inflight)
    );
    assign full      = count == CW'(BD);
    assign wr        = push & ~full;
    assign pop       = o_valid & i_ready;
    // Credits count words already buffered plus reads still inside the RAM.
    assign used      = (CW+1)'(count) + (CW+1)'(inflight);
    assign o_ready_m = ~i_rst & (used < (CW+1)'(BD));
    assign o_valid   = ~i_rst & (count != '0);
    assign o_count   = i_rst ? '0 : count;
    assign o_err     = ~i_rst & err;
    assign o_data    = mem[rptr];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (wr) wptr <= (wptr == PW'(BD-1)) ? '0 : wptr + 1'b1;
            if (pop) rptr <= (rptr == PW'(BD-1)) ? '0 : rptr + 1'b1;
            count <= count + CW'(wr) - CW'(pop);
            if ((i_ren & ~o_ready_m) | (push & full)) err <= 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (wr) mem[wptr] <= i_rdata;
    end
endmodule
